rupt_priority_sequencer: RTL and testbench
==========================================

# rupt_priority_sequencer

Interrupt ("rupt") controller for the A15 rupt-service datapath. It latches the ten AGC interrupt requests and resolves them by fixed priority. At an instruction boundary it grants one request by driving RUPTOR_ and a frozen vector index/address. It then tracks the service window until RESUME and raises a rupt-lock alarm if service runs too long.

## Interface
Parameters:
- NSRC, 10, number of rupt sources (index 1..NSRC; 0 = none)
- VEC_BASE, 12'o4000, vector base address; vector = VEC_BASE + 4*index
- RLOCK_CYC, 1024, service-window cycles before RUPTLOCK asserts

Ports:
- CLOCK  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- GOJAM  in  1  synchronous restart: clears latches, state, alarm
- RUPTREQ  in  NSRC  request pulses; bit 0 = T6RUPT (highest) … bit 9 = HNDRUPT (lowest)
- INHINT  in  1  interrupts inhibited when high
- OVF_  in  1  low = overflow in A; inhibits grant
- EXTEND  in  1  extracode pending; inhibits grant
- NISQ  in  1  instruction-boundary strobe (grant window)
- RRPA  in  1  rupt address read (acknowledge)
- RESUME  in  1  end of interrupt service
- PENDING  out  NSRC  request latches
- RUPTOR_  out  1  low = grant outstanding
- RPTAD  out  4  granted index (1..10), 0 when idle
- RPTADDR  out  12  VEC_BASE + 4*RPTAD
- IIP  out  1  interrupt in progress (SERVICE state)
- RUPTLOCK  out  1  sticky rupt-lock alarm

## Operation
- Latches: PENDING[i] is set by RUPTREQ[i] and cleared only by an RRPA acknowledge of index i+1, or by GOJAM/rst. If a set and a clear of the same bit coincide, the set wins.
- eligible = |PENDING & !INHINT & OVF_ & !EXTEND.
- FSM states: IDLE, GRANT, SERVICE.
  - IDLE: if eligible & NISQ, go to GRANT. Load RPTAD with the lowest set PENDING bit index + 1.
  - GRANT: RUPTOR_ = 0 and RPTAD is frozen. Higher-priority arrivals and changes in inhibits are ignored. On RRPA, clear PENDING[RPTAD-1] and go to SERVICE.
  - SERVICE: IIP = 1. No grants are made and RPTAD is held. On RESUME, go to IDLE with RPTAD = 0.
- RRPA or RESUME arriving in a state that does not expect it is ignored.
- Watchdog: a counter runs in SERVICE and is cleared on leaving SERVICE. When the count reaches RLOCK_CYC, RUPTLOCK is set. The counter saturates. RUPTLOCK clears only on GOJAM/rst.
- GOJAM has priority over every other input in the same cycle.

## Timing
- Reset/GOJAM values: PENDING = 0, RUPTOR_ = 1, RPTAD = 0, RPTADDR = VEC_BASE, IIP = 0, RUPTLOCK = 0, state IDLE, counter 0.
- A RUPTREQ pulse in cycle k makes PENDING visible at edge k+1.
- The grant decision uses registered PENDING. With NISQ at cycle k+1, RUPTOR_ falls at edge k+2. A request arriving in the same cycle as NISQ misses that window.
- RRPA at cycle g: after edge g+1, RUPTOR_ = 1, IIP = 1, and the PENDING bit is cleared.
- RESUME at cycle s: after edge s+1, IIP = 0 and RPTAD = 0. The earliest next grant needs NISQ at s+1 and appears at s+2.
- RUPTLOCK rises at the edge after which the counter equals RLOCK_CYC, i.e. RLOCK_CYC cycles after entering SERVICE.
- All outputs are registered except RPTADDR, which is combinational from RPTAD.
- rst mid-operation: immediate asynchronous return to reset values. An in-flight grant is lost and its pending bit is cleared.

## Structure
- Package agc_rupt_pkg contains:
  - the state enum (IDLE, GRANT, SERVICE)
  - NSRC_DEF
  - source-index constants (T6RUPT=1, T5RUPT=2, T3RUPT=3, T4RUPT=4, KEYRUPT1=5, KEYRUPT2=6, UPRUPT=7, DNRUPT=8, RADARUPT=9, HNDRUPT=10)
  - VEC_BASE_DEF
- Sub-module rupt_prio_enc is a combinational lowest-index-first encoder: NSRC bits in, 4-bit index out, 0 for none.

## Test plan
- Pulse RUPTREQ[4] (KEYRUPT1), NISQ next cycle → RUPTOR_ = 0, RPTAD = 5, RPTADDR = 12'o4024. RRPA → PENDING[4] = 0, IIP = 1. RESUME → IIP = 0, RPTAD = 0.
- Set bits 9, 2, 0 together, then repeatedly grant/RRPA/RESUME → service order is RPTAD 1, 3, 10, with vectors 4004, 4014, 4050.
- Pending bit 3 while INHINT = 1, or OVF_ = 0, or EXTEND = 1, with NISQ pulsing → RUPTOR_ stays 1. Drop the inhibit and pulse NISQ → grant RPTAD = 4.
- In GRANT with RPTAD = 8, pulse RUPTREQ[0] → RPTAD stays 8 and PENDING[0] = 1. After RESUME and NISQ → RPTAD = 1.
- RUPTREQ[2] coincides with the RRPA that acknowledges index 3 → PENDING[2] remains 1.
- RLOCK_CYC = 16, stay in SERVICE for 20 cycles → RUPTLOCK = 1 at cycle 16 and persists through RESUME. GOJAM → all outputs return to reset values. Also assert rst during GRANT → asynchronous reset values.

Source files
------------

// File: rtl/agc_rupt_pkg.sv
// Shared types and constants for the AGC rupt-service datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package agc_rupt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SERVICE = 2'd2
    } rupt_state_t;

    localparam int NSRC_DEF = 10;

    localparam logic [11:0] VEC_BASE_DEF = 12'o4000;

    // Source indices as seen on RPTAD; RUPTREQ bit i carries index i+1.
    localparam logic [3:0] T6RUPT   = 4'd1;
    localparam logic [3:0] T5RUPT   = 4'd2;
    localparam logic [3:0] T3RUPT   = 4'd3;
    localparam logic [3:0] T4RUPT   = 4'd4;
    localparam logic [3:0] KEYRUPT1 = 4'd5;
    localparam logic [3:0] KEYRUPT2 = 4'd6;
    localparam logic [3:0] UPRUPT   = 4'd7;
    localparam logic [3:0] DNRUPT   = 4'd8;
    localparam logic [3:0] RADARUPT = 4'd9;
    localparam logic [3:0] HNDRUPT  = 4'd10;

endpackage

// File: rtl/rupt_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins, reported as bit index + 1 (0 = none).
// Latency: combinational.
// Backpressure: none.
module rupt_prio_enc #(
    parameter int NSRC = 10
) (
    input  logic [NSRC-1:0] req,
    output logic [3:0]      idx
);

    // Scan from the lowest-priority end so the lowest set bit overwrites last.
    always_comb begin
        idx = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i + 1);
            end
        end
    end

endmodule

// File: rtl/rupt_priority_sequencer.sv
// Latches rupt requests, grants the highest-priority one at an instruction boundary, tracks service, watchdogs lock-up.
// Latency: request visible in PENDING one edge later; grant one edge after NISQ; RPTADDR combinational from RPTAD.
// Backpressure: grant waits for RRPA, next grant waits for RESUME; inhibits only block entry into GRANT.
import agc_rupt_pkg::*;

module rupt_priority_sequencer #(
    parameter int          NSRC      = NSRC_DEF,
    parameter logic [11:0] VEC_BASE  = VEC_BASE_DEF,
    parameter int          RLOCK_CYC = 1024
) (
    input  logic            CLOCK,
    input  logic            rst,
    input  logic            GOJAM,
    input  logic [NSRC-1:0] RUPTREQ,
    input  logic            INHINT,
    input  logic            OVF_,
    input  logic            EXTEND,
    input  logic            NISQ,
    input  logic            RRPA,
    input  logic            RESUME,
    output logic [NSRC-1:0] PENDING,
    output logic            RUPTOR_,
    output logic [3:0]      RPTAD,
    output logic [11:0]     RPTADDR,
    output logic            IIP,
    output logic            RUPTLOCK
);

    localparam int          CW  = $clog2(RLOCK_CYC + 1);
    localparam logic [CW-1:0] LIM = CW'(RLOCK_CYC);

    rupt_state_t     state;
    rupt_state_t     state_nxt;
    logic [3:0]      rptad_nxt;
    logic [3:0]      enc_idx;
    logic [NSRC-1:0] clr_mask;
    logic [NSRC-1:0] pending_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            lock_nxt;
    logic            eligible;

    rupt_prio_enc #(
        .NSRC (NSRC)
    ) u_enc (
        .req (PENDING),
        .idx (enc_idx)
    );

    assign eligible = (|PENDING) && !INHINT && OVF_ && !EXTEND;

    // Vector address is a pure function of the frozen index.
    assign RPTADDR = VEC_BASE + {6'd0, RPTAD, 2'b00};

    // Next-state logic; GOJAM overrides every transition. The acknowledge clears only the granted latch.
    always_comb begin
        state_nxt = state;
        rptad_nxt = RPTAD;
        clr_mask  = '0;
        case (state)
            IDLE: begin
                if (eligible && NISQ) begin
                    state_nxt = GRANT;
                    rptad_nxt = enc_idx;
                end
            end
            GRANT: begin
                if (RRPA) begin
                    state_nxt = SERVICE;
                    for (int i = 0; i < NSRC; i++) begin
                        clr_mask[i] = (RPTAD == 4'(i + 1));
                    end
                end
            end
            SERVICE: begin
                if (RESUME) begin
                    state_nxt = IDLE;
                    rptad_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                rptad_nxt = 4'd0;
            end
        endcase
        if (GOJAM) begin
            state_nxt = IDLE;
            rptad_nxt = 4'd0;
            clr_mask  = '0;
        end
    end

    // Request latches: a new request beats a coincident acknowledge of the same bit.
    always_comb begin
        pending_nxt = (PENDING & ~clr_mask) | RUPTREQ;
        if (GOJAM) begin
            pending_nxt = '0;
        end
    end

    // Service-window watchdog: counts while staying in SERVICE, saturates, zeroes on exit; alarm is sticky.
    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != SERVICE) begin
            cnt_nxt = '0;
        end else if (state == SERVICE && cnt != LIM) begin
            cnt_nxt = cnt + CW'(1);
        end
        lock_nxt = RUPTLOCK || (state_nxt == SERVICE && cnt_nxt == LIM);
        if (GOJAM) begin
            cnt_nxt  = '0;
            lock_nxt = 1'b0;
        end
    end

    // State, latches and all registered outputs.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            PENDING  <= '0;
            RPTAD    <= 4'd0;
            RUPTOR_  <= 1'b1;
            IIP      <= 1'b0;
            RUPTLOCK <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            PENDING  <= pending_nxt;
            RPTAD    <= rptad_nxt;
            RUPTOR_  <= (state_nxt != GRANT);
            IIP      <= (state_nxt == SERVICE);
            RUPTLOCK <= lock_nxt;
            cnt      <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rupt_priority_sequencer.sv
// Directed bench for the rupt priority sequencer.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled at the same point.
// Backpressure: n/a.
module tb_rupt_priority_sequencer;

    localparam int NSRC = 10;

    logic            CLOCK = 1'b0;
    logic            rst;
    logic            GOJAM;
    logic [NSRC-1:0] RUPTREQ;
    logic            INHINT;
    logic            OVF_;
    logic            EXTEND;
    logic            NISQ;
    logic            RRPA;
    logic            RESUME;
    logic [NSRC-1:0] PENDING;
    logic            RUPTOR_;
    logic [3:0]      RPTAD;
    logic [11:0]     RPTADDR;
    logic            IIP;
    logic            RUPTLOCK;

    int checks   = 0;
    int failures = 0;

    rupt_priority_sequencer #(
        .NSRC      (NSRC),
        .VEC_BASE  (12'o4000),
        .RLOCK_CYC (16)
    ) dut (
        .CLOCK    (CLOCK),
        .rst      (rst),
        .GOJAM    (GOJAM),
        .RUPTREQ  (RUPTREQ),
        .INHINT   (INHINT),
        .OVF_     (OVF_),
        .EXTEND   (EXTEND),
        .NISQ     (NISQ),
        .RRPA     (RRPA),
        .RESUME   (RESUME),
        .PENDING  (PENDING),
        .RUPTOR_  (RUPTOR_),
        .RPTAD    (RPTAD),
        .RPTADDR  (RPTADDR),
        .IIP      (IIP),
        .RUPTLOCK (RUPTLOCK)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic pulse_req(input logic [NSRC-1:0] m);
        RUPTREQ = m;
        tick();
        RUPTREQ = '0;
    endtask

    task automatic pulse_nisq();
        NISQ = 1'b1;
        tick();
        NISQ = 1'b0;
    endtask

    task automatic pulse_rrpa();
        RRPA = 1'b1;
        tick();
        RRPA = 1'b0;
    endtask

    task automatic pulse_resume();
        RESUME = 1'b1;
        tick();
        RESUME = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pending"},  32'(PENDING),  32'h0);
        chk({tag, ".ruptor_"},  32'(RUPTOR_),  32'h1);
        chk({tag, ".rptad"},    32'(RPTAD),    32'h0);
        chk({tag, ".rptaddr"},  32'(RPTADDR),  32'(12'o4000));
        chk({tag, ".iip"},      32'(IIP),      32'h0);
        chk({tag, ".ruptlock"}, 32'(RUPTLOCK), 32'h0);
    endtask

    logic [3:0]  exp_idx  [3];
    logic [11:0] exp_addr [3];

    initial begin
        rst = 1'b1; GOJAM = 1'b0; RUPTREQ = '0; INHINT = 1'b0; OVF_ = 1'b1;
        EXTEND = 1'b0; NISQ = 1'b0; RRPA = 1'b0; RESUME = 1'b0;
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();

        // KEYRUPT1 full grant/ack/resume cycle
        pulse_req(10'h010);
        chk("t1.pending", 32'(PENDING), 32'h010);
        chk("t1.ruptor_idle", 32'(RUPTOR_), 32'h1);
        pulse_nisq();
        chk("t1.ruptor_", 32'(RUPTOR_), 32'h0);
        chk("t1.rptad", 32'(RPTAD), 32'd5);
        chk("t1.rptaddr", 32'(RPTADDR), 32'(12'o4024));
        pulse_rrpa();
        chk("t1.pending_clr", 32'(PENDING), 32'h0);
        chk("t1.iip", 32'(IIP), 32'h1);
        chk("t1.ruptor_srv", 32'(RUPTOR_), 32'h1);
        chk("t1.rptad_srv", 32'(RPTAD), 32'd5);
        pulse_resume();
        chk("t1.iip_end", 32'(IIP), 32'h0);
        chk("t1.rptad_end", 32'(RPTAD), 32'h0);

        // Priority order for three simultaneous requests
        exp_idx[0] = 4'd1;  exp_addr[0] = 12'o4004;
        exp_idx[1] = 4'd3;  exp_addr[1] = 12'o4014;
        exp_idx[2] = 4'd10; exp_addr[2] = 12'o4050;
        pulse_req(10'b10_0000_0101);
        chk("t2.pending", 32'(PENDING), 32'h205);
        for (int k = 0; k < 3; k++) begin
            pulse_nisq();
            chk($sformatf("t2.rptad%0d", k), 32'(RPTAD), 32'(exp_idx[k]));
            chk($sformatf("t2.addr%0d", k), 32'(RPTADDR), 32'(exp_addr[k]));
            pulse_rrpa();
            pulse_resume();
        end
        chk("t2.pending_end", 32'(PENDING), 32'h0);

        // Inhibits block the grant
        pulse_req(10'h008);
        INHINT = 1'b1;
        pulse_nisq();
        chk("t3.inhint", 32'(RUPTOR_), 32'h1);
        INHINT = 1'b0; OVF_ = 1'b0;
        pulse_nisq();
        chk("t3.ovf", 32'(RUPTOR_), 32'h1);
        OVF_ = 1'b1; EXTEND = 1'b1;
        pulse_nisq();
        chk("t3.extend", 32'(RUPTOR_), 32'h1);
        EXTEND = 1'b0;
        pulse_rrpa();
        chk("t3.rrpa_idle_pending", 32'(PENDING), 32'h008);
        chk("t3.rrpa_idle_iip", 32'(IIP), 32'h0);
        pulse_nisq();
        chk("t3.grant", 32'(RUPTOR_), 32'h0);
        chk("t3.rptad", 32'(RPTAD), 32'd4);
        pulse_rrpa();
        pulse_resume();

        // Higher-priority arrival during GRANT does not preempt
        pulse_req(10'h080);
        pulse_nisq();
        chk("t4.rptad", 32'(RPTAD), 32'd8);
        pulse_req(10'h001);
        chk("t4.rptad_frozen", 32'(RPTAD), 32'd8);
        chk("t4.pending", 32'(PENDING), 32'h081);
        pulse_rrpa();
        chk("t4.pending_ack", 32'(PENDING), 32'h001);
        pulse_resume();
        pulse_nisq();
        chk("t4.rptad_next", 32'(RPTAD), 32'd1);
        pulse_rrpa();
        pulse_resume();

        // Set wins over coincident clear; request in the NISQ cycle misses that window
        pulse_req(10'h004);
        pulse_nisq();
        chk("t5.rptad", 32'(RPTAD), 32'd3);
        RUPTREQ = 10'h004; RRPA = 1'b1;
        tick();
        RUPTREQ = '0; RRPA = 1'b0;
        chk("t5.pending_kept", 32'(PENDING), 32'h004);
        chk("t5.iip", 32'(IIP), 32'h1);
        pulse_resume();
        pulse_nisq();
        pulse_rrpa();
        pulse_resume();
        chk("t5.pending_gone", 32'(PENDING), 32'h0);
        RUPTREQ = 10'h040; NISQ = 1'b1;
        tick();
        RUPTREQ = '0; NISQ = 1'b0;
        chk("t5.miss_ruptor_", 32'(RUPTOR_), 32'h1);
        chk("t5.miss_pending", 32'(PENDING), 32'h040);
        pulse_nisq();
        chk("t5.late_rptad", 32'(RPTAD), 32'd7);
        pulse_rrpa();
        pulse_resume();

        // Watchdog: 16 cycles in SERVICE trips RUPTLOCK
        pulse_req(10'h002);
        pulse_nisq();
        pulse_rrpa();
        chk("t6.lock_start", 32'(RUPTLOCK), 32'h0);
        repeat (15) tick();
        chk("t6.lock_15", 32'(RUPTLOCK), 32'h0);
        tick();
        chk("t6.lock_16", 32'(RUPTLOCK), 32'h1);
        repeat (4) tick();
        chk("t6.lock_20", 32'(RUPTLOCK), 32'h1);
        pulse_resume();
        chk("t6.lock_resume", 32'(RUPTLOCK), 32'h1);
        chk("t6.iip_resume", 32'(IIP), 32'h0);
        pulse_req(10'h020);
        GOJAM = 1'b1; RUPTREQ = 10'h100; NISQ = 1'b1;
        tick();
        GOJAM = 1'b0; RUPTREQ = '0; NISQ = 1'b0;
        chk_reset_vals("gojam");

        // Asynchronous reset while a grant is outstanding
        pulse_req(10'h040);
        pulse_nisq();
        chk("t7.ruptor_", 32'(RUPTOR_), 32'h0);
        chk("t7.rptad", 32'(RPTAD), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("async");
        tick();
        rst = 1'b0;
        tick();
        chk("t7.idle_after", 32'(RUPTOR_), 32'h1);
        chk("t7.pending_after", 32'(PENDING), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
